// File: rtl/half_adder_pkg.sv
// ----------------------------------------------------------------------------
// half_adder_pkg
//   Shared constants and helpers for the half_adder_pipe slice.
//   - DEF_WIDTH / DEF_CNT_W : default lane count and statistics counter width.
//   - SAT_W                 : working width of the saturating helper. Counters
//                             up to SAT_W bits wide are supported.
//   - cnt_mask()            : all-ones value of a w-bit counter, in SAT_W bits.
//   - sat_inc()             : saturating add, evaluated one bit wider than
//                             SAT_W so the overflow can never wrap.
// ----------------------------------------------------------------------------
package half_adder_pkg;

   localparam int DEF_WIDTH = 1;
   localparam int DEF_CNT_W = 16;
   localparam int SAT_W     = 32;

   // Saturation limit of a w-bit counter. Written as a loop so that it also
   // works for w == SAT_W, where a (1 << w) - 1 expression would overflow.
   function automatic logic [SAT_W-1:0] cnt_mask(input int w);
      logic [SAT_W-1:0] m;
      m = '0;
      for (int i = 0; i < SAT_W; i++) begin
         if (i < w) m[i] = 1'b1;
      end
      return m;
   endfunction

   // cur + inc, clamped to max_val. The extra top bit of s catches the carry
   // out, so the result stays correct even when cur + inc passes 2^SAT_W.
   function automatic logic [SAT_W-1:0] sat_inc(
      input logic [SAT_W-1:0] cur,
      input logic [SAT_W-1:0] inc,
      input logic [SAT_W-1:0] max_val
   );
      logic [SAT_W:0] s;
      s = {1'b0, cur} + {1'b0, inc};
      if (s > {1'b0, max_val}) return max_val;
      return s[SAT_W-1:0];
   endfunction

endpackage

// File: rtl/half_adder_cell.sv
// ----------------------------------------------------------------------------
// half_adder_cell
//   Single-lane combinational half adder.
//   Ports:
//     a, b   : operand bits
//     sum    : a XOR b
//     carry  : a AND b
// ----------------------------------------------------------------------------
module half_adder_cell (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b;
   assign carry = a & b;

endmodule

// File: rtl/half_adder_pipe.sv
// ----------------------------------------------------------------------------
// half_adder_pipe
//   WIDTH independent 1-bit half adders behind a single registered stage with
//   valid/ready on both sides, plus saturating statistics counters.
//   Ports:
//     clk, rst_n            : clock (rising edge), async active-low reset
//     in_valid / in_ready   : operand handshake; in_ready = !out_valid || out_ready
//     a, b                  : WIDTH-bit operands, one bit per lane
//     out_valid / out_ready : result handshake
//     sum, carry            : registered per-lane XOR / AND
//     clear_stats           : synchronous clear of both counters (wins over
//                             a simultaneous accept)
//     pair_count            : accepted operand pairs, saturating
//     carry_count           : total carry bits produced, saturating
// ----------------------------------------------------------------------------
module half_adder_pipe
   import half_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry,
   input  logic             clear_stats,
   output logic [CNT_W-1:0] pair_count,
   output logic [CNT_W-1:0] carry_count
);

   localparam int              STAGES  = 1;
   localparam logic [SAT_W-1:0] CNT_MAX = cnt_mask(CNT_W);

   // --------------------------------------------------------------------------
   // Lane array
   // --------------------------------------------------------------------------
   logic [WIDTH-1:0] sum_w;
   logic [WIDTH-1:0] carry_w;

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      half_adder_cell u_cell (
         .a     (a[i]),
         .b     (b[i]),
         .sum   (sum_w[i]),
         .carry (carry_w[i])
      );
   end

   // --------------------------------------------------------------------------
   // Handshake
   // vld_pipe[0] is the accept strobe entering the stage, vld_pipe[STAGES]
   // the registered valid leaving it.
   // --------------------------------------------------------------------------
   logic [STAGES:0] vld_pipe;
   logic            vld_q;
   logic            acc;

   assign in_ready  = !vld_q || out_ready;
   assign acc       = in_valid && in_ready;
   assign vld_pipe  = {vld_q, acc};
   assign out_valid = vld_pipe[STAGES];

   // The stage advances whenever it may accept. If nothing is accepted at
   // that edge the stage is either empty already or just handed its result
   // downstream, so valid falls. During a stall in_ready is low and the
   // whole stage holds. Operand bits only reach the flops on an accept, so
   // X on a/b while in_valid is low never gets captured.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= 1'b0;
         sum   <= '0;
         carry <= '0;
      end else if (in_ready) begin
         vld_q <= vld_pipe[0];
         if (acc) begin
            sum   <= sum_w;
            carry <= carry_w;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Statistics
   // --------------------------------------------------------------------------
   logic [SAT_W-1:0] carry_pop;

   always_comb begin
      carry_pop = '0;
      for (int i = 0; i < WIDTH; i++) begin
         carry_pop = carry_pop + SAT_W'(carry_w[i]);
      end
   end

   // Clear takes priority over counting a pair accepted at the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pair_count  <= '0;
         carry_count <= '0;
      end else if (clear_stats) begin
         pair_count  <= '0;
         carry_count <= '0;
      end else if (acc) begin
         pair_count  <= CNT_W'(sat_inc(SAT_W'(pair_count), SAT_W'(1), CNT_MAX));
         carry_count <= CNT_W'(sat_inc(SAT_W'(carry_count), carry_pop, CNT_MAX));
      end
   end

endmodule

// File: tb/tb_half_adder_pipe.sv
module tb_half_adder_pipe;

   localparam int W  = 4;
   localparam int CW = 16;
   localparam int SW = 2;

   typedef struct packed {
      logic [W-1:0] sum;
      logic [W-1:0] carry;
   } res_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready, out_valid, out_ready, clear_stats;
   logic [W-1:0]  a, b, sum, carry;
   logic [CW-1:0] pair_count, carry_count;

   logic          s_in_valid, s_in_ready, s_out_valid;
   logic [W-1:0]  s_a, s_b, s_sum, s_carry;
   logic [SW-1:0] s_pair_count, s_carry_count;

   int checks = 0;
   int errors = 0;
   res_t exp_q[$];

   always #5 clk = ~clk;

   half_adder_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .carry(carry), .clear_stats(clear_stats),
      .pair_count(pair_count), .carry_count(carry_count)
   );

   half_adder_pipe #(.WIDTH(W), .CNT_W(SW)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .a(s_a), .b(s_b), .out_valid(s_out_valid), .out_ready(1'b1),
      .sum(s_sum), .carry(s_carry), .clear_stats(1'b0),
      .pair_count(s_pair_count), .carry_count(s_carry_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: every negedge where a transfer is about to happen, compare the
   // presented result against the oldest expected entry.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", {24'h0, sum, carry}, 32'hffff_ffff);
         end else begin
            res_t e;
            e = exp_q.pop_front();
            chk("result", {24'h0, sum, carry}, {24'h0, e.sum, e.carry});
         end
      end
   end

   // Drive one pair (called at posedge+1); expected result is pushed when the
   // block is seen ready, i.e. the pair will be accepted at the next edge.
   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic [W-1:0] es, input logic [W-1:0] ec);
      bit done = 0;
      in_valid = 1'b1; a = ta; b = tb;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back('{sum: es, carry: ec});
            done = 1;
         end
         @(posedge clk); #1;
      end
      if (!done) chk("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0; a = 'x; b = 'x;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clear_stats = 1'b0;
      a = 'x; b = 'x;
      s_in_valid = 1'b0; s_a = '0; s_b = '0;
      #12;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_sum_carry", {24'h0, sum, carry}, 32'd0);
      chk("rst_counts", {pair_count, carry_count}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

      // Single-lane truth table, back to back
      send(4'b0000, 4'b0000, 4'b0000, 4'b0000);
      send(4'b0000, 4'b0001, 4'b0001, 4'b0000);
      send(4'b0001, 4'b0000, 4'b0001, 4'b0000);
      send(4'b0001, 4'b0001, 4'b0000, 4'b0001);
      // idle with X operands: nothing may be captured
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("tt_pair_count", 32'(pair_count), 32'd4);
      chk("tt_carry_count", 32'(carry_count), 32'd1);
      chk("idle_no_valid", {31'd0, out_valid}, 32'd0);
      chk("idle_hold_result", {24'h0, sum, carry}, {24'h0, 4'b0000, 4'b0001});
      @(posedge clk); #1;

      // Multi-lane, no inter-lane carry
      send(4'b1011, 4'b0110, 4'b1101, 4'b0010);
      @(negedge clk);
      chk("ml_pair_count", 32'(pair_count), 32'd5);
      chk("ml_carry_count", 32'(carry_count), 32'd2);
      @(posedge clk); #1;

      // Backpressure
      out_ready = 1'b0;
      send(4'b0001, 4'b0001, 4'b0000, 4'b0001);
      in_valid = 1'b1; a = 4'b1111; b = 4'b1111;   // must be ignored
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_result", {24'h0, sum, carry}, {24'h0, 4'b0000, 4'b0001});
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_pair_count", 32'(pair_count), 32'd6);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; a = 'x; b = 'x;
      out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      chk("bp_drained", {31'd0, out_valid}, 32'd0);
      chk("bp_carry_count", 32'(carry_count), 32'd3);

      // Clear coincident with accept: counters cleared, result still delivered
      clear_stats = 1'b1;
      send(4'b0001, 4'b0001, 4'b0000, 4'b0001);
      clear_stats = 1'b0;
      chk("clr_counts", {pair_count, carry_count}, 32'd0);
      send(4'b0011, 4'b0001, 4'b0010, 4'b0001);
      @(negedge clk);
      chk("clr_recount", {pair_count, carry_count}, {16'd1, 16'd1});
      @(posedge clk); #1;

      // Asynchronous reset while a result is stalled
      out_ready = 1'b0;
      send(4'b0101, 4'b0111, 4'b0010, 4'b0101);
      @(negedge clk);
      chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_sum_carry", {24'h0, sum, carry}, 32'd0);
      chk("arst_counts", {pair_count, carry_count}, 32'd0);
      exp_q.delete();
      @(negedge clk); rst_n = 1'b1;
      #1;
      chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;

      // Saturation on the 2-bit-counter instance
      @(posedge clk); #1;
      s_in_valid = 1'b1; s_a = 4'hF; s_b = 4'hF;
      repeat (2) @(posedge clk);
      #1;
      chk("sat_carry_2", 32'(s_carry_count), 32'd3);
      chk("sat_pair_2", 32'(s_pair_count), 32'd2);
      chk("sat_result", {24'h0, s_sum, s_carry}, {24'h0, 4'h0, 4'hF});
      repeat (2) @(posedge clk);
      #1;
      s_in_valid = 1'b0;
      chk("sat_pair_4", 32'(s_pair_count), 32'd3);
      chk("sat_carry_4", 32'(s_carry_count), 32'd3);

      repeat (3) @(posedge clk);
      #1;
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
